// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and transaction sequencer for the shared
// MSI snoop bus. One cache owns the bus at a time; its message is broadcast,
// snoop acks from every other cache are collected, then memory is read unless
// a cache supplied the line or the op needs no data.
//
// Optional feature: define BUS_ARB_WATCHDOG_EN to enable a SNOOP/MEM watchdog
// that aborts a transaction after SNOOP_TIMEOUT cycles (abort_o pulses with
// done_o). Without the macro the transaction waits indefinitely and abort_o
// is tied low.

module bus_arbiter #(
  parameter int unsigned NUM_PROCS     = 4,
  parameter int unsigned ADDR_SIZE     = 32,
  parameter int unsigned SNOOP_TIMEOUT = 15,
  localparam int unsigned IDX_W        = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PROCS-1:0]           req_i,
  input  logic [2*NUM_PROCS-1:0]         req_op_i,
  input  logic [ADDR_SIZE*NUM_PROCS-1:0] req_addr_i,
  output logic [NUM_PROCS-1:0]           gnt_o,
  output logic                           bus_msg_valid_o,
  output logic [1:0]                     bus_msg_op_o,
  output logic [ADDR_SIZE-1:0]           bus_msg_addr_o,
  output logic [IDX_W-1:0]               bus_msg_src_o,
  input  logic [NUM_PROCS-1:0]           snoop_ack_i,
  input  logic [NUM_PROCS-1:0]           snoop_flush_i,
  output logic                           mem_rd_o,
  input  logic                           mem_ack_i,
  output logic [NUM_PROCS-1:0]           done_o,
  output logic                           abort_o
);

  // Bus message op encodings that never need a memory read
  localparam logic [1:0] OP_BUSUPGR = 2'b10;
  localparam logic [1:0] OP_FLUSH   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SNOOP = 2'd1,
    S_MEM   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Reject configurations the arbiter cannot support
  if (NUM_PROCS < 1) begin : g_bad_procs
    $error("bus_arbiter: NUM_PROCS must be at least 1");
  end
  if (SNOOP_TIMEOUT < 1) begin : g_bad_timeout
    $error("bus_arbiter: SNOOP_TIMEOUT must be at least 1");
  end

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       win_q, win_d;
  logic [1:0]             op_q, op_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [NUM_PROCS-1:0]   ack_q, ack_d;
  logic                   flush_q, flush_d;

  logic [1:0]             op_arr [NUM_PROCS];
  logic [ADDR_SIZE-1:0]   addr_arr [NUM_PROCS];

  logic                   pick_found_c;
  logic [IDX_W-1:0]       pick_idx_c;
  int unsigned            cand_c;
  logic [NUM_PROCS-1:0]   win_mask_c;
  logic                   ack_all_c;
  logic                   flush_hit_c;
  logic                   op_skips_mem_c;
  logic [IDX_W-1:0]       ptr_next_c;

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = (SNOOP_TIMEOUT > 1) ? $clog2(SNOOP_TIMEOUT) : 1;

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic                   timeout_c;

  // Last permitted SNOOP/MEM cycle has been reached without completion
  assign timeout_c = (cnt_q == CNT_W'(SNOOP_TIMEOUT - 1));
`endif

  // Unpack the flattened per-requester op and address fields
  for (genvar g = 0; g < NUM_PROCS; g++) begin : g_unpack
    assign op_arr[g]   = req_op_i[2*g +: 2];
    assign addr_arr[g] = req_addr_i[ADDR_SIZE*g +: ADDR_SIZE];
  end

  // Round-robin scan: first requester at or after ptr, wrapping
  always_comb begin : arb_scan
    pick_found_c = 1'b0;
    pick_idx_c   = '0;
    cand_c       = 0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      cand_c = 32'(ptr_q) + i;
      if (cand_c >= NUM_PROCS) begin
        cand_c = cand_c - NUM_PROCS;
      end
      if (!pick_found_c && req_i[IDX_W'(cand_c)]) begin
        pick_found_c = 1'b1;
        pick_idx_c   = IDX_W'(cand_c);
      end
    end
  end

  // One-hot mask of the latched winner
  always_comb begin : win_decode
    win_mask_c        = '0;
    win_mask_c[win_q] = 1'b1;
  end

  // Snoop completion (including this cycle's acks) and line-supplied detection
  assign ack_all_c      = &(ack_q | snoop_ack_i | win_mask_c);
  assign flush_hit_c    = flush_q | (|(snoop_flush_i & snoop_ack_i & ~win_mask_c));
  assign op_skips_mem_c = (op_q == OP_BUSUPGR) || (op_q == OP_FLUSH);
  assign ptr_next_c     = (32'(win_q) >= NUM_PROCS - 1) ? '0 : win_q + IDX_W'(1);

  // Next-state and datapath update logic
  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    addr_d  = addr_q;
    ack_d   = ack_q;
    flush_d = flush_q;
`ifdef BUS_ARB_WATCHDOG_EN
    cnt_d   = cnt_q;
    abort_d = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_found_c) begin
          win_d   = pick_idx_c;
          op_d    = op_arr[pick_idx_c];
          addr_d  = addr_arr[pick_idx_c];
          ack_d   = '0;
          flush_d = 1'b0;
`ifdef BUS_ARB_WATCHDOG_EN
          cnt_d   = '0;
`endif
          state_d = S_SNOOP;
        end
      end
      S_SNOOP: begin
        ack_d   = ack_q | snoop_ack_i;
        flush_d = flush_hit_c;
`ifdef BUS_ARB_WATCHDOG_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        if (ack_all_c) begin
          state_d = (op_skips_mem_c || flush_hit_c) ? S_DONE : S_MEM;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        else if (timeout_c) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end
`endif
      end
      S_MEM: begin
`ifdef BUS_ARB_WATCHDOG_EN
        cnt_d = cnt_q + CNT_W'(1);
`endif
        if (mem_ack_i) begin
          state_d = S_DONE;
        end
`ifdef BUS_ARB_WATCHDOG_EN
        else if (timeout_c) begin
          state_d = S_DONE;
          abort_d = 1'b1;
        end
`endif
      end
      S_DONE: begin
        ptr_d   = ptr_next_c;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      ack_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      flush_q <= flush_d;
    end
  end

`ifdef BUS_ARB_WATCHDOG_EN
  // Watchdog counter and abort flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign abort_o = abort_q;
`else
  assign abort_o = 1'b0;
`endif

  // Outputs decoded purely from registered state
  always_comb begin : out_decode
    gnt_o           = '0;
    bus_msg_valid_o = 1'b0;
    mem_rd_o        = 1'b0;
    done_o          = '0;
    bus_msg_op_o    = op_q;
    bus_msg_addr_o  = addr_q;
    bus_msg_src_o   = win_q;
    unique case (state_q)
      S_SNOOP: begin
        gnt_o           = win_mask_c;
        bus_msg_valid_o = 1'b1;
      end
      S_MEM: begin
        gnt_o    = win_mask_c;
        mem_rd_o = 1'b1;
      end
      S_DONE: begin
        gnt_o  = win_mask_c;
        done_o = win_mask_c;
      end
      default: begin
      end
    endcase
  end

endmodule
